// File: rtl/input_feeder_pkg.sv
// Shared definitions for the input feeder: image geometry defaults, state encoding and pixel count.
`ifndef BIN_LEN
`define BIN_LEN 8
`endif
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 4
`endif
`ifndef INPUT_HEIGHT
`define INPUT_HEIGHT 3
`endif
`ifndef INPUT_WIDTH_LOG
`define INPUT_WIDTH_LOG 2
`endif
`ifndef INPUT_HEIGHT_LOG
`define INPUT_HEIGHT_LOG 2
`endif

package input_feeder_pkg;

    localparam int unsigned INPUT_PIXELS = `INPUT_WIDTH * `INPUT_HEIGHT;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_SERVE   = 3'd2,
        ST_PRESENT = 3'd3,
        ST_RELEASE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/input_image_buffer.sv
// Simple dual-port image store: write port for loading, registered read port for the feeder.
module input_image_buffer
    import input_feeder_pkg::*;
#(
    parameter int unsigned DATA_W = `BIN_LEN,
    parameter int unsigned DEPTH  = INPUT_PIXELS,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Storage is intentionally not reset so a reloaded image survives a feeder reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Read register doubles as the presented pixel, so it holds between fetches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/input_feeder.sv
// Serves a stored image pixel-by-pixel in raster order over a req/ready handshake.
module input_feeder
    import input_feeder_pkg::*;
#(
    parameter int unsigned BIN_LEN      = `BIN_LEN,
    parameter int unsigned INPUT_WIDTH  = `INPUT_WIDTH,
    parameter int unsigned INPUT_HEIGHT = `INPUT_HEIGHT,
    parameter int unsigned ADDR_W       = $clog2(INPUT_WIDTH * INPUT_HEIGHT)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         load_en,
    input  logic [ADDR_W-1:0]            load_addr,
    input  logic [BIN_LEN-1:0]           load_data,
    input  logic                         start,
    input  logic                         input_req,
    output logic [BIN_LEN-1:0]           input_val,
    output logic                         input_ready,
    output logic                         busy,
    output logic                         done,
    output logic [`INPUT_WIDTH_LOG-1:0]  width_index,
    output logic [`INPUT_HEIGHT_LOG-1:0] height_index
);

    localparam int unsigned PIXELS = INPUT_WIDTH * INPUT_HEIGHT;
    localparam int unsigned WIDX_W = `INPUT_WIDTH_LOG;
    localparam int unsigned HIDX_W = `INPUT_HEIGHT_LOG;

    state_e            state_q, state_d;
    logic [WIDX_W-1:0] width_index_q, width_index_d;
    logic [HIDX_W-1:0] height_index_q, height_index_d;
    logic              input_ready_q, input_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              last_pixel_c;
    logic              wr_en_c;
    logic              rd_en_c;
    logic [ADDR_W-1:0] rd_addr_c;

    assign last_pixel_c = (width_index_q == WIDX_W'(INPUT_WIDTH - 1)) &&
                          (height_index_q == HIDX_W'(INPUT_HEIGHT - 1));
    assign wr_en_c   = load_en && (state_q == ST_IDLE) && (32'(load_addr) < PIXELS);
    assign rd_en_c   = (state_q == ST_FETCH);
    assign rd_addr_c = ADDR_W'(32'(height_index_q) * INPUT_WIDTH + 32'(width_index_q));

    input_image_buffer #(
        .DATA_W (BIN_LEN),
        .DEPTH  (PIXELS),
        .ADDR_W (ADDR_W)
    ) u_buffer (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en_c),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (rd_en_c),
        .rd_addr (rd_addr_c),
        .rd_data (input_val)
    );

    // Next state, index advance, and registered handshake/status outputs.
    always_comb begin
        state_d        = state_q;
        width_index_d  = width_index_q;
        height_index_d = height_index_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    width_index_d  = '0;
                    height_index_d = '0;
                    state_d        = ST_FETCH;
                end
            end
            ST_FETCH:   state_d = ST_SERVE;
            ST_SERVE:   if (input_req) state_d = ST_PRESENT;
            ST_PRESENT: state_d = ST_RELEASE;
            ST_RELEASE: begin
                if (!input_req) begin
                    if (last_pixel_c) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                        if (width_index_q == WIDX_W'(INPUT_WIDTH - 1)) begin
                            width_index_d  = '0;
                            height_index_d = height_index_q + HIDX_W'(1);
                        end else begin
                            width_index_d = width_index_q + WIDX_W'(1);
                        end
                    end
                end
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        input_ready_d = (state_d == ST_PRESENT);
        busy_d        = (state_d == ST_FETCH) || (state_d == ST_SERVE) ||
                        (state_d == ST_PRESENT) || (state_d == ST_RELEASE);
        done_d        = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            width_index_q  <= '0;
            height_index_q <= '0;
            input_ready_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            width_index_q  <= width_index_d;
            height_index_q <= height_index_d;
            input_ready_q  <= input_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign input_ready  = input_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign width_index  = width_index_q;
    assign height_index = height_index_q;

endmodule

// File: tb/tb_input_feeder.sv
// Randomized self-checking bench for input_feeder against a raster-order image model.
module tb_input_feeder;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned N  = W * H;
    localparam int unsigned AW = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           load_en;
    logic [AW-1:0]  load_addr;
    logic [7:0]     load_data;
    logic           start;
    logic           input_req;
    logic [7:0]     input_val;
    logic           input_ready;
    logic           busy;
    logic           done;
    logic [1:0]     width_index;
    logic [1:0]     height_index;

    int checks = 0;
    int errors = 0;
    logic [7:0] img [N];

    input_feeder #(
        .BIN_LEN      (8),
        .INPUT_WIDTH  (W),
        .INPUT_HEIGHT (H),
        .ADDR_W       (AW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .start        (start),
        .input_req    (input_req),
        .input_val    (input_val),
        .input_ready  (input_ready),
        .busy         (busy),
        .done         (done),
        .width_index  (width_index),
        .height_index (height_index)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Model rule: a write lands only when the feeder is idle and the address is in range.
    task automatic load(input int addr, input logic [7:0] data, input bit idle);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        step();
        load_en = 1'b0;
        if (idle && addr < int'(N)) img[addr] = data;
    endtask

    task automatic start_feed();
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic serve_pixel(input int k, input int pre, input int hold, input bit inject, input bit first);
        int  lat;
        bit  got;
        int  exp_lat;
        for (int i = 0; i < pre; i++) begin
            step();
            check("no_ready_unrequested", 32'(input_ready), 32'd0);
        end
        exp_lat   = (first && pre == 0) ? 1 : 0;
        input_req = 1'b1;
        got       = 1'b0;
        lat       = 0;
        for (int t = 0; t < 8 && !got; t++) begin
            step();
            if (input_ready === 1'b1) begin
                got = 1'b1;
                lat = t;
            end
        end
        check("ready_seen", 32'(got), 32'd1);
        check("ready_latency", 32'(lat), 32'(exp_lat));
        check("pixel_value", 32'(input_val), 32'(img[k]));
        check("width_index", 32'(width_index), 32'(k % W));
        check("height_index", 32'(height_index), 32'(k / W));
        check("done_midstream", 32'(done), 32'd0);
        if (inject) begin
            load_en   = 1'b1;
            load_addr = AW'(3);
            load_data = 8'hFF;
            start     = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            step();
            load_en = 1'b0;
            start   = 1'b0;
            check("single_ready", 32'(input_ready), 32'd0);
            check("hold_value", 32'(input_val), 32'(img[k]));
        end
        input_req = 1'b0;
        if (hold == 0) begin
            step();
            load_en = 1'b0;
            start   = 1'b0;
            check("single_ready", 32'(input_ready), 32'd0);
            check("hold_value", 32'(input_val), 32'(img[k]));
        end
        step();
        if (k == int'(N) - 1) begin
            check("done_pulse", 32'(done), 32'd1);
            check("busy_in_done", 32'(busy), 32'd0);
            step();
            check("done_single", 32'(done), 32'd0);
            check("busy_after_done", 32'(busy), 32'd0);
        end else begin
            check("done_low", 32'(done), 32'd0);
            check("busy_fetch", 32'(busy), 32'd1);
            check("next_width_index", 32'(width_index), 32'((k + 1) % W));
            check("next_height_index", 32'(height_index), 32'((k + 1) / W));
            check("fetch_hold_value", 32'(input_val), 32'(img[k]));
            step();
            check("next_value_2_after_fall", 32'(input_val), 32'(img[k + 1]));
            check("no_ready_in_serve", 32'(input_ready), 32'd0);
        end
    endtask

    task automatic run_image(input int hold0, input bit rnd, input bit inject);
        start_feed();
        for (int k = 0; k < int'(N); k++) begin
            int pre;
            int hold;
            pre  = rnd ? int'($urandom_range(0, 2)) : 0;
            hold = rnd ? int'($urandom_range(0, 3)) : 0;
            if (k == 0 && hold0 > 0) hold = hold0;
            if (inject && k == 1 && hold == 0) hold = 1;
            serve_pixel(k, pre, hold, inject && k == 1, k == 0);
        end
    endtask

    initial begin
        bit got;
        reset     = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        start     = 1'b0;
        input_req = 1'b0;
        for (int i = 0; i < int'(N); i++) img[i] = 8'h00;
        step();
        step();
        check("rst_input_val", 32'(input_val), 32'd0);
        check("rst_input_ready", 32'(input_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_width_index", 32'(width_index), 32'd0);
        check("rst_height_index", 32'(height_index), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        step();

        for (int k = 0; k < int'(N); k++) load(k, 8'(8'h10 + k), 1'b1);
        for (int a = int'(N); a < 16; a++) load(a, 8'hEE, 1'b1);

        // Well-behaved consumer, then hold/random consumer with ignored write/start.
        run_image(0, 1'b0, 1'b0);
        run_image(5, 1'b1, 1'b1);

        // Reset during RELEASE of pixel 5.
        start_feed();
        for (int k = 0; k < 5; k++) serve_pixel(k, 0, int'($urandom_range(0, 2)), 1'b0, k == 0);
        input_req = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 8 && !got; t++) begin
            step();
            if (input_ready === 1'b1) got = 1'b1;
        end
        check("p5_ready_seen", 32'(got), 32'd1);
        check("p5_value", 32'(input_val), 32'(img[5]));
        step();
        #2;
        reset = 1'b1;
        #1;
        check("amid_rst_ready", 32'(input_ready), 32'd0);
        check("amid_rst_busy", 32'(busy), 32'd0);
        check("amid_rst_done", 32'(done), 32'd0);
        check("amid_rst_width_index", 32'(width_index), 32'd0);
        check("amid_rst_height_index", 32'(height_index), 32'd0);
        input_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        step();
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        run_image(0, 1'b1, 1'b0);

        // Request held in IDLE is never acknowledged.
        input_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_req_no_ready", 32'(input_ready), 32'd0);
        end
        run_image(0, 1'b0, 1'b0);

        // Fresh random image.
        for (int k = 0; k < int'(N); k++) load(k, 8'($urandom), 1'b1);
        run_image(int'($urandom_range(0, 4)), 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_feeder.md
# input_feeder

Responder side of the processing unit's input handshake: stores one `INPUT_HEIGHT` × `INPUT_WIDTH` input image and serves its pixels in raster order.
- Each pixel is presented on `input_val` and acknowledged with a one-cycle `input_ready` pulse whenever the processing unit raises `input_req`.
- The image is written through a load port before `start`.
- The block sits between host/DMA loading logic and `processing_unit`; `done` marks that the last pixel has been consumed.

## Interface
- `BIN_LEN`, default `` `BIN_LEN ``: pixel width in bits.
- `INPUT_WIDTH`, default `` `INPUT_WIDTH ``: image columns.
- `INPUT_HEIGHT`, default `` `INPUT_HEIGHT ``: image rows.
- `ADDR_W`, default `$clog2(INPUT_WIDTH*INPUT_HEIGHT)`: load address width.

Ports:
- `clock`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all control state.
- `load_en`  in  1  write strobe for the image buffer.
- `load_addr`  in  `ADDR_W`  raster address, `row*INPUT_WIDTH + col`.
- `load_data`  in  `BIN_LEN`  pixel value.
- `start`  in  1  begin serving from pixel 0.
- `input_req`  in  1  level request from the processing unit.
- `input_val`  out  `BIN_LEN`  current pixel.
- `input_ready`  out  1  one-cycle acknowledge; `input_val` is valid in this cycle.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `done` is asserted.
- `done`  out  1  one-cycle pulse after the last pixel is released.
- `width_index`  out  `` `INPUT_WIDTH_LOG ``  column of the current pixel.
- `height_index`  out  `` `INPUT_HEIGHT_LOG ``  row of the current pixel.

## Operation
- **Reset values:** `input_val` = 0, `input_ready` = 0, `busy` = 0, `done` = 0, both indices = 0, state IDLE. Buffer contents are not cleared.
- **Loading:**
  - `load_en` writes `load_data` at `load_addr` in IDLE only.
  - Writes while busy are dropped.
  - Writes with `load_addr` ≥ `INPUT_WIDTH*INPUT_HEIGHT` are dropped.
- **State machine:**
  - IDLE: when `start` = 1, clear the indices and go to FETCH.
  - FETCH: present address `height_index*INPUT_WIDTH + width_index` to the buffer (synchronous read). Capture the data into `input_val` at the end of the cycle, then go to SERVE.
  - SERVE: when `input_req` = 1, go to PRESENT.
  - PRESENT: `input_ready` = 1 for exactly this cycle, then go to RELEASE.
  - RELEASE: hold `input_val` while `input_req` = 1. When `input_req` = 0:
    - if this is the last pixel (`width_index` = `INPUT_WIDTH`-1 and `height_index` = `INPUT_HEIGHT`-1), go to DONE;
    - otherwise advance the indices (column wraps to 0 and row increments) and go to FETCH.
  - DONE: `done` = 1, `busy` = 0, then go to IDLE.
- **Hold rule:** `input_val` never changes from PRESENT until `input_req` has been observed low. The consumer loads `input_val` into its down counter the cycle after it sees `input_ready`.
- **Ignored starts:** `start` outside IDLE is ignored.
- **Request without start:** `input_req` while IDLE or DONE is never acknowledged.
- **Reset mid-transfer:** returns to IDLE immediately with the reset values above. No partial `done` is produced.
- **Indices** never exceed `INPUT_WIDTH`-1 / `INPUT_HEIGHT`-1.

## Timing
- `start` sampled at edge E0: FETCH during E0–E1, `input_val` valid after E1, SERVE from E1.
- `input_req` sampled high in SERVE at edge En: `input_ready` is high during En–En+1. Minimum request-to-ready latency is 1 cycle from entering SERVE.
- `input_req` falls after edge Em in RELEASE: the next pixel is on `input_val` 2 edges later (FETCH, then SERVE).
- `done` occurs exactly 1 cycle after RELEASE observes `input_req` low for the last pixel.
- **Throughput:** at most one pixel per 4 cycles (SERVE, PRESENT, RELEASE, FETCH).

## Structure
- Shared package: the state enum typedef (IDLE, FETCH, SERVE, PRESENT, RELEASE, DONE) and the image size constant `INPUT_PIXELS = INPUT_WIDTH*INPUT_HEIGHT`. These sit alongside the existing `BIN_LEN` / `INPUT_*` definitions in `sys_defs.svh`.
- One sub-module, `input_image_buffer`: simple dual-port RAM with a write port for loading and a synchronous-read port for the feeder, `INPUT_PIXELS` × `BIN_LEN`, no reset on storage.

## Test plan
Configuration for all scenarios: `INPUT_WIDTH`=4, `INPUT_HEIGHT`=3, `BIN_LEN`=8.
- **Full image, well-behaved consumer:** load pixel k = 8'h10+k for k = 0..11, `start`, consumer raises `input_req` and drops it 1 cycle after `input_ready`. Expect 12 `input_ready` pulses with values 10..1B in order, `done` one cycle after the 12th release, `busy` low afterward.
- **Hold check:** keep `input_req` high for 5 cycles after `input_ready`. Expect exactly one ready pulse and `input_val` stable (value 10) until `input_req` falls; second pixel 11 appears 2 cycles after the fall.
- **Index wrap:** after the 4th pixel (13) is released, expect `width_index` = 0 and `height_index` = 1. After the 8th, expect `height_index` = 2.
- **Ignored writes and starts:** `load_en` with addr 3, data FF while busy, and `start` pulsed mid-image. Expect pixel 3 still served as 13, sequence unbroken, single `done`.
- **Reset mid-transfer:** assert `reset` asynchronously during RELEASE of pixel 5. Expect immediate `input_ready`/`busy`/`done` = 0 and indices 0. A new `start` re-serves from 10 using the retained buffer contents.
- **Request before start:** `input_req` held high for 10 cycles in IDLE. Expect no `input_ready`; after `start`, the first ready arrives with 10.
